ifetch_unit: RTL and testbench

Instruction fetch unit. It reads the current PC from the PC register, issues a word read to instruction memory over a req/ready handshake, and presents the fetched instruction downstream with valid/accept. It produces pc_en/pc_next so the PC register advances only when a fetch completes. It sits between the PC register and the decode stage of the MIPS datapath.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ifetch_unit.sv | 100 ++++++++++
 tb/tb_ifetch_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, PC step and reset vector.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_WAIT  = 3'd1,
      S_HOLD  = 3'd2,
      S_DRAIN = 3'd3,
      S_FAULT = 3'd4
   } fetch_state_t;

   localparam int unsigned PC_STEP  = 4;
   localparam logic [31:0] RESET_PC = '0;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: reads the PC, issues one memory word read at a time
// over req/ready, holds the fetched instruction until decode accepts it, and
// pulses pc_en so the PC register advances only on a completed fetch.
module ifetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned PC_STEP = cpu_pkg::PC_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_accept,
   output logic              pc_en,
   output logic [ADDR_W-1:0] pc_next,
   output logic              fault
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] addr;

   // The address latch drives the bus directly, so it stays stable while mem_req=1.
   assign mem_addr = addr;

   // Fetch FSM with all outputs registered; pc_en defaults low for a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         addr        <= '0;
         mem_req     <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         pc_en       <= 1'b0;
         pc_next     <= '0;
         fault       <= 1'b0;
      end else begin
         pc_en <= 1'b0;
         unique case (state)
            S_REQ: begin
               if (pc_in[1:0] != 2'b00) begin
                  fault <= 1'b1;
                  state <= S_FAULT;
               end else begin
                  addr    <= pc_in;
                  mem_req <= 1'b1;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (flush) begin
                     state <= S_REQ;
                  end else begin
                     instr_out   <= mem_rdata;
                     instr_pc    <= addr;
                     pc_next     <= addr + ADDR_W'(PC_STEP);
                     pc_en       <= 1'b1;
                     instr_valid <= 1'b1;
                     state       <= S_HOLD;
                  end
               end else if (flush) begin
                  // The issued request cannot be aborted; wait out its response.
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= S_REQ;
               end
            end
            S_HOLD: begin
               if (instr_accept || flush) begin
                  instr_valid <= 1'b0;
                  state       <= S_REQ;
               end
            end
            S_FAULT: begin
               if (flush) begin
                  fault <= 1'b0;
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed fetches push expected
// instruction/PC and pc_next values; a monitor pops them on delivery/pc_en.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_accept;
   logic        pc_en;
   logic [31:0] pc_next;
   logic        fault;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [31:0] exp_pcn_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_dat_q[$];

   ifetch_unit #(.ADDR_W(32), .DATA_W(32), .PC_STEP(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_in        (pc_in),
      .flush        (flush),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .instr_out    (instr_out),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .instr_accept (instr_accept),
      .pc_en        (pc_en),
      .pc_next      (pc_next),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   // Memory contents: word at address A reads as A ^ 0xC0DE0000.
   assign mem_rdata = mem_addr ^ 32'hC0DE_0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expectations whenever the DUT pulses pc_en or delivers an instruction.
   always @(negedge clk) begin
      if (!rst) begin
         if (pc_en) begin
            if (exp_pcn_q.size() == 0) check("unexpected_pc_en", 32'd1, 32'd0);
            else check("pc_next", pc_next, exp_pcn_q.pop_front());
         end
         if (instr_valid && instr_accept) begin
            if (exp_pc_q.size() == 0) begin
               check("unexpected_delivery", 32'd1, 32'd0);
            end else begin
               check("instr_pc", instr_pc, exp_pc_q.pop_front());
               check("instr_out", instr_out, exp_dat_q.pop_front());
            end
         end
      end
   end

   // Starts with the DUT in S_REQ; mem_ready arrives after 'delay' extra wait cycles,
   // then the instruction is held 'hold' cycles before being accepted.
   task automatic fetch(input logic [31:0] pc, input int unsigned delay, input int unsigned hold,
                        input logic [31:0] exp_data, input logic [31:0] exp_next);
      pc_in     = pc;
      mem_ready = 1'b0;
      exp_pcn_q.push_back(exp_next);
      exp_pc_q.push_back(pc);
      exp_dat_q.push_back(exp_data);
      for (int unsigned i = 1; i <= delay + 1; i++) begin
         tick();
         check("req_high", {31'd0, mem_req}, 32'd1);
         check("req_addr", mem_addr, pc);
         if (i == delay + 1) mem_ready = 1'b1;
      end
      tick();
      mem_ready = 1'b0;
      check("valid_set", {31'd0, instr_valid}, 32'd1);
      check("req_drop", {31'd0, mem_req}, 32'd0);
      for (int unsigned h = 0; h < hold; h++) begin
         mem_ready = 1'b1;   // stray ready in S_HOLD must be ignored
         tick();
         check("hold_valid", {31'd0, instr_valid}, 32'd1);
         check("hold_data", instr_out, exp_data);
         check("hold_pc", instr_pc, pc);
         check("hold_no_req", {31'd0, mem_req}, 32'd0);
      end
      mem_ready    = 1'b0;
      instr_accept = 1'b1;
      tick();
      instr_accept = 1'b0;
      check("valid_clr", {31'd0, instr_valid}, 32'd0);
      check("req_idle", {31'd0, mem_req}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, "_pc_en"}, {31'd0, pc_en}, 32'd0);
      check({tag, "_fault"}, {31'd0, fault}, 32'd0);
      check({tag, "_instr_out"}, instr_out, 32'd0);
      check({tag, "_instr_pc"}, instr_pc, 32'd0);
      check({tag, "_pc_next"}, pc_next, 32'd0);
   endtask

   initial begin
      rst          = 1'b1;
      pc_in        = 32'h0;
      flush        = 1'b0;
      mem_ready    = 1'b0;
      instr_accept = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_outputs("rst");

      // 1: immediate ready at PC 0
      fetch(32'h0000_0000, 0, 0, 32'hC0DE_0000, 32'h0000_0004);

      // 2: three cycles of wait states at 0x40
      fetch(32'h0000_0040, 3, 0, 32'hC0DE_0040, 32'h0000_0044);

      // 3: decode stalls for 5 cycles
      fetch(32'h0000_0010, 0, 5, 32'hC0DE_0010, 32'h0000_0014);

      // 4: flush during S_WAIT; response drained and dropped
      pc_in = 32'h0000_0080;
      tick();
      check("fl_req", {31'd0, mem_req}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      pc_in = 32'h0000_0200;
      check("drain_req", {31'd0, mem_req}, 32'd1);
      check("drain_addr", mem_addr, 32'h0000_0080);
      tick();
      check("drain_req2", {31'd0, mem_req}, 32'd1);
      check("drain_addr2", mem_addr, 32'h0000_0080);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("drain_done_req", {31'd0, mem_req}, 32'd0);
      check("drain_no_valid", {31'd0, instr_valid}, 32'd0);
      fetch(32'h0000_0200, 1, 0, 32'hC0DE_0200, 32'h0000_0204);

      // 5: misaligned PC faults until flush
      pc_in = 32'h0000_0006;
      tick();
      check("fault_set", {31'd0, fault}, 32'd1);
      check("fault_no_req", {31'd0, mem_req}, 32'd0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("fault_sticky", {31'd0, fault}, 32'd1);
      check("fault_no_valid", {31'd0, instr_valid}, 32'd0);
      flush = 1'b1;
      pc_in = 32'h0000_0008;
      tick();
      flush = 1'b0;
      check("fault_clr", {31'd0, fault}, 32'd0);
      fetch(32'h0000_0008, 0, 1, 32'hC0DE_0008, 32'h0000_000C);

      // 6: PC wrap, then reset while waiting on memory
      fetch(32'hFFFF_FFFC, 0, 0, 32'h3F21_FFFC, 32'h0000_0000);
      pc_in = 32'h0000_0100;
      tick();
      check("pre_rst_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("midrst");
      fetch(32'h0000_0020, 1, 1, 32'hC0DE_0020, 32'h0000_0024);

      tick();
      check("pending_pc_en", exp_pcn_q.size(), 32'd0);
      check("pending_instr", exp_pc_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
